trng_harvester: RTL
===================

// Module: trng_harvester
// PURPOSE
//  Consumer side of the TRNG entropy flip-flop: samples its raw, asynchronous output bit,
//  removes bias with a von Neumann extractor, and packs the surviving bits into WIDTH-bit words.
//  Words go out on a valid/ready handshake to the system (UART/SPI) domain.
//  Includes a repetition-count health test that halts output when the source looks stuck.
// PARAMETERS
//  SAMPLE_DIV  16  clk cycles between raw samples (>=2)
//  WIDTH       8   bits per output word (>=2)
//  REP_LIMIT   32  consecutive identical raw samples that trip health_fail (>=2)
// PORTS
//  clk          in   1      system clock; only clock in the block
//  rst          in   1      asynchronous, active-high reset
//  en           in   1      harvest enable; low = flush and clear health_fail
//  raw_in       in   1      raw entropy bit from the flip-flop; asynchronous to clk
//  data_out     out  WIDTH  harvested word; stable while data_valid=1
//  data_valid   out  1      word available
//  data_ready   in   1      consumer accepts; transfer when data_valid & data_ready
//  health_fail  out  1      sticky repetition-count failure
// BEHAVIOUR
//  Reset: data_out=0, data_valid=0, health_fail=0; sync flops, prescaler, FSM, accumulator,
//   bit count and repetition counter all 0.
//  Sync: raw_in passes through 2 flops (reset 0); samples use the 2nd flop, which is 2 clk behind raw_in.
//  Prescaler: counts 0..SAMPLE_DIV-1 while en & !health_fail & !stall.
//   tick=1 for one cycle when count==SAMPLE_DIV-1, then count wraps to 0.
//  Extractor FSM (state FIRST/SECOND, register a):
//   FIRST + tick  -> a<=sample, go to SECOND.
//   SECOND + tick -> if sample!=a, emit bit a; always return to FIRST.
//   Pairs 00 and 11 are discarded. 10 emits 1; 01 emits 0.
//  Accumulator: emit -> acc<={acc[WIDTH-2:0],bit}, cnt++. First emitted bit ends up in the MSB.
//  Word complete (cnt==WIDTH):
//   if output is free, or is being taken in the same cycle, load data_out, set data_valid=1, clear cnt.
//   Otherwise stall=1: prescaler and FSM freeze, acc is held. On the handshake cycle, data_out<=acc
//   and data_valid stays 1. No bits are lost and no words are dropped.
//  Handshake: with data_valid=1 and data_ready=1 and no pending word, data_valid<=0 next cycle.
//   data_out holds its value until the next load. data_ready while !data_valid is ignored.
//  Health: each tick compares the sample with the previous sample.
//   Equal -> rep++ (saturating); different -> rep<=1.
//   rep reaching REP_LIMIT -> health_fail<=1 the next cycle. In the same cycle: data_valid<=0,
//   acc/cnt/FSM cleared, prescaler halted.
//  en low (synchronous): prescaler, FSM, acc, cnt and rep cleared; health_fail cleared.
//   A pending data_valid word is kept and can still be read.
//  en high again: harvesting restarts from FSM=FIRST with prescaler=0.
//  rst mid-word: everything returns to reset values immediately; the partial word is lost.
//  Latency: 2 sync + up to SAMPLE_DIV per sample; at least 2*WIDTH ticks per word.
// STRUCTURE
//  trng_pkg: FSM state typedef (ST_FIRST, ST_SECOND), default parameter constants.
//  Sub-module trng_sync2: 2-flop synchronizer with async reset, reused for other async inputs.
//  Everything else is flat in trng_harvester.
// TESTING (SAMPLE_DIV=4, WIDTH=8, REP_LIMIT=32; raw_in driven 1 value per 4-clk sample slot)
//  1. Pairs 10,01 repeated 4x, data_ready=1 -> one word data_out=8'hAA, data_valid high 1 cycle.
//  2. Pairs 00,11 interleaved with 8x pair 10 -> only 8'hFF; the 00/11 pairs add no bits.
//  3. data_ready=0, then 16 pairs 01 -> first 8'h00 held with data_valid=1 and prescaler frozen.
//     Raise data_ready -> second 8'h00 appears next cycle, then harvesting resumes.
//  4. raw_in held 1 for 32 samples -> health_fail=1 and data_valid=0.
//     en=0 for 1 cycle -> health_fail=0, and the next word is built from fresh pairs.
//  5. 5 bits harvested, then rst pulsed asynchronously mid-cycle -> all outputs 0 at once.
//     After release, 8 new bits give a word with none of the old bits.
//  6. Word pending, en dropped -> data_out and data_valid kept until the handshake; no new word.

Source files
------------

// File: rtl/trng_pkg.sv
// Shared types and default constants for the TRNG harvester.
package trng_pkg;

    // Von Neumann extractor phase: waiting for the first or the second bit of a pair.
    typedef enum logic [0:0] {
        ST_FIRST  = 1'b0,
        ST_SECOND = 1'b1
    } trng_state_e;

    localparam int SAMPLE_DIV_DEF = 16;
    localparam int WIDTH_DEF      = 8;
    localparam int REP_LIMIT_DEF  = 32;

    // Saturating increment used by the repetition counter.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value, input logic [15:0] limit);
        logic [15:0] result;
        if (value >= limit) begin
            result = limit;
        end else begin
            result = value + 16'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/trng_sync2.sv
// Two-flop synchronizer for a single asynchronous input bit.
module trng_sync2 (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Two-stage capture; the second stage is the only one safe to consume.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/trng_harvester.sv
// Samples the raw entropy bit, debiases it with a von Neumann extractor,
// packs surviving bits into words and runs a repetition-count health test.
module trng_harvester
    import trng_pkg::*;
#(
    parameter int SAMPLE_DIV = SAMPLE_DIV_DEF,
    parameter int WIDTH      = WIDTH_DEF,
    parameter int REP_LIMIT  = REP_LIMIT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             raw_in,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             health_fail
);

    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int REP_W = $clog2(REP_LIMIT + 1);

    localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
    localparam logic [REP_W-1:0] REP_MAX  = REP_W'(REP_LIMIT);

    // Synchronized raw sample
    logic w_sample;

    // Prescaler
    logic [DIV_W-1:0] r_div;
    logic             w_run;
    logic             w_tick;

    // Extractor FSM
    trng_state_e r_state;
    trng_state_e w_state_nxt;
    logic        r_a;
    logic        w_a_nxt;
    logic        w_emit;
    logic        w_bit;

    // Accumulator and output
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_data_out;
    logic             r_data_valid;
    logic             w_word_done;
    logic             w_out_free;
    logic             w_load;
    logic             w_stall;

    // Health test
    logic [REP_W-1:0] r_rep;
    logic             r_prev;
    logic             r_health_fail;
    logic             w_trip;
    logic [15:0]      w_rep_inc;

    trng_sync2 u_sync (
        .i_clk (clk),
        .i_rst (rst),
        .i_d   (raw_in),
        .o_q   (w_sample)
    );

    assign w_word_done = (r_cnt == CNT_FULL);
    assign w_out_free  = !r_data_valid || data_ready;
    assign w_load      = w_word_done && w_out_free;
    assign w_stall     = w_word_done && !w_out_free;
    assign w_trip      = en && !r_health_fail && (r_rep >= REP_MAX);
    assign w_run       = en && !r_health_fail && !w_stall;
    assign w_tick      = w_run && (r_div == DIV_MAX);
    assign w_rep_inc   = sat_inc16(16'(r_rep), 16'(REP_MAX));

    // Sample-rate prescaler; frozen while a finished word waits for the consumer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div <= {DIV_W{1'b0}};
        end else if (!en || w_trip) begin
            r_div <= {DIV_W{1'b0}};
        end else if (w_run) begin
            if (r_div == DIV_MAX) begin
                r_div <= {DIV_W{1'b0}};
            end else begin
                r_div <= r_div + {{(DIV_W-1){1'b0}}, 1'b1};
            end
        end else begin
            r_div <= r_div;
        end
    end

    // Extractor state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_FIRST;
            r_a     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_a     <= w_a_nxt;
        end
    end

    // Extractor next state: keep the first bit of a pair, emit it if the second differs.
    always_comb begin
        w_state_nxt = r_state;
        w_a_nxt     = r_a;
        w_emit      = 1'b0;
        w_bit       = r_a;
        if (!en || w_trip) begin
            w_state_nxt = ST_FIRST;
            w_a_nxt     = 1'b0;
        end else if (w_tick) begin
            case (r_state)
                ST_FIRST: begin
                    w_a_nxt     = w_sample;
                    w_state_nxt = ST_SECOND;
                end
                ST_SECOND: begin
                    w_emit      = (w_sample != r_a);
                    w_state_nxt = ST_FIRST;
                end
                default: begin
                    w_state_nxt = ST_FIRST;
                end
            endcase
        end else begin
            w_state_nxt = r_state;
        end
    end

    // Word assembly and valid/ready output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc        <= {WIDTH{1'b0}};
            r_cnt        <= {CNT_W{1'b0}};
            r_data_out   <= {WIDTH{1'b0}};
            r_data_valid <= 1'b0;
        end else if (!en) begin
            // Pending word survives a disable and can still be read out.
            r_acc <= {WIDTH{1'b0}};
            r_cnt <= {CNT_W{1'b0}};
            if (r_data_valid && data_ready) begin
                r_data_valid <= 1'b0;
            end else begin
                r_data_valid <= r_data_valid;
            end
        end else if (w_trip) begin
            r_acc        <= {WIDTH{1'b0}};
            r_cnt        <= {CNT_W{1'b0}};
            r_data_valid <= 1'b0;
        end else if (w_load) begin
            r_data_out   <= r_acc;
            r_data_valid <= 1'b1;
            r_cnt        <= {CNT_W{1'b0}};
        end else begin
            if (w_emit) begin
                r_acc <= {r_acc[WIDTH-2:0], w_bit};
                r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                r_acc <= r_acc;
            end
            if (r_data_valid && data_ready) begin
                r_data_valid <= 1'b0;
            end else begin
                r_data_valid <= r_data_valid;
            end
        end
    end

    // Repetition-count health test with sticky failure flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rep         <= {REP_W{1'b0}};
            r_prev        <= 1'b0;
            r_health_fail <= 1'b0;
        end else if (!en) begin
            r_rep         <= {REP_W{1'b0}};
            r_health_fail <= 1'b0;
        end else if (w_trip) begin
            r_health_fail <= 1'b1;
        end else if (w_tick) begin
            r_prev <= w_sample;
            if (w_sample == r_prev) begin
                r_rep <= w_rep_inc[REP_W-1:0];
            end else begin
                r_rep <= {{(REP_W-1){1'b0}}, 1'b1};
            end
        end else begin
            r_rep <= r_rep;
        end
    end

    assign data_out    = r_data_out;
    assign data_valid  = r_data_valid;
    assign health_fail = r_health_fail;

endmodule
